program_loader: RTL and testbench

Byte-stream boot loader that programs the CPU's instruction memory and controls when the CPU is released to run. It accepts a framed byte stream (length, instruction words, checksum) over a valid/ready handshake and drives the CPU's `instruction_in` / `load_address` / `load_instruction` write port one word at a time. It holds the CPU's `pc_reset` asserted until a complete, checksum-verified image is in memory.

---
 rtl/program_loader.sv | 139 +++++++++++++
 tb/tb_program_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: framed byte-stream boot loader that writes CPU instruction memory
// and releases the CPU from reset once a checksum-verified image is loaded.
`default_nettype none

module program_loader #(
  parameter logic [15:0] ADDR_BASE = 16'h0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] instruction_in,
  output logic [15:0] load_address,
  output logic        load_instruction,
  output logic        pc_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LEN_HI  = 4'd1,
    LEN_LO  = 4'd2,
    DATA_HI = 4'd3,
    DATA_LO = 4'd4,
    WRITE   = 4'd5,
    CHECK   = 4'd6,
    RUN     = 4'd7,
    ERROR   = 4'd8
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state;
  state_t      next_state;
  logic [7:0]  len_hi;
  logic [15:0] remaining;
  logic [7:0]  sum;
  logic        accept;
  logic        start_ok;
  logic [15:0] len_full;

  assign accept   = byte_valid & byte_ready;
  assign start_ok = start & ((state == IDLE) | (state == RUN) | (state == ERROR));
  assign len_full = {len_hi, byte_in};

  always_comb begin
    next_state = state;
    case (state)
      IDLE, RUN, ERROR: if (start_ok) next_state = LEN_HI;
      LEN_HI:  if (accept) next_state = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_full} > MAX_LEN) next_state = ERROR;
          else if (len_full == 16'd0)     next_state = CHECK;
          else                            next_state = DATA_HI;
        end
      end
      DATA_HI: if (accept) next_state = DATA_LO;
      DATA_LO: if (accept) next_state = WRITE;
      WRITE:   next_state = (remaining == 16'd1) ? CHECK : DATA_HI;
      CHECK: begin
        if (accept) next_state = (byte_in == sum) ? RUN : ERROR;
      end
      default: next_state = IDLE;
    endcase
  end

  // Status outputs are registered by decoding the next state, so they line up
  // with the state they describe without any output decode after the flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      pc_reset         <= 1'b1;
      load_instruction <= 1'b0;
      byte_ready       <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      state            <= next_state;
      pc_reset         <= (next_state != RUN);
      load_instruction <= (next_state == WRITE);
      byte_ready       <= (next_state == LEN_HI) || (next_state == LEN_LO) ||
                          (next_state == DATA_HI) || (next_state == DATA_LO) ||
                          (next_state == CHECK);
      busy             <= (next_state == LEN_HI) || (next_state == LEN_LO) ||
                          (next_state == DATA_HI) || (next_state == DATA_LO) ||
                          (next_state == WRITE) || (next_state == CHECK);
      done             <= (next_state == RUN);
      error            <= (next_state == ERROR);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_hi         <= 8'd0;
      remaining      <= 16'd0;
      sum            <= 8'd0;
      instruction_in <= 16'd0;
      load_address   <= ADDR_BASE;
    end else begin
      if (start_ok) begin
        sum          <= 8'd0;
        load_address <= ADDR_BASE;
      end
      case (state)
        LEN_HI: if (accept) begin
          len_hi <= byte_in;
          sum    <= sum + byte_in;
        end
        LEN_LO: if (accept) begin
          remaining <= len_full;
          sum       <= sum + byte_in;
        end
        DATA_HI: if (accept) begin
          instruction_in[15:8] <= byte_in;
          sum                  <= sum + byte_in;
        end
        DATA_LO: if (accept) begin
          instruction_in[7:0] <= byte_in;
          sum                 <= sum + byte_in;
        end
        WRITE: begin
          load_address <= load_address + 16'd1;
          remaining    <= remaining - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: frames, checksum errors, oversize, gaps, reset.
`default_nettype none

module tb_program_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] instruction_in;
  logic [15:0] load_address;
  logic        load_instruction;
  logic        pc_reset;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  logic [31:0] writes[$];

  program_loader #(.ADDR_BASE(16'h0000), .MAX_WORDS(256)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .instruction_in(instruction_in),
    .load_address(load_address), .load_instruction(load_instruction),
    .pc_reset(pc_reset), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && load_instruction) writes.push_back({load_address, instruction_in});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents the byte and returns at the negedge after it transfers.
  // byte_valid is left high so back-to-back bytes keep it asserted through WRITE.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("byte_ready_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_nominal(input bit gaps);
    logic [7:0] frame [7];
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    for (int i = 0; i < 7; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 3));
      send_byte(frame[i]);
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_nominal_writes(input string tag);
    chk({tag, "_count"}, 32'(writes.size()), 32'd2);
    if (writes.size() == 2) begin
      chk({tag, "_w0"}, writes[0], {16'h0000, 16'h1234});
      chk({tag, "_w1"}, writes[1], {16'h0001, 16'hABCD});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_outs"},
        {pc_reset, load_instruction, byte_ready, busy, done, error},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk({tag, "_addr_data"}, {load_address, instruction_in}, 32'h0000_0000);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_pc_reset", {31'd0, pc_reset}, 32'd1);

    // Nominal load
    writes.delete();
    pulse_start();
    chk("start_ready_busy", {byte_ready, busy}, 2'b11);
    send_nominal(1'b0);
    chk("nom_run", {pc_reset, done, error, busy, byte_ready}, 5'b01000);
    check_nominal_writes("nom");

    // Bad checksum
    writes.delete();
    pulse_start();
    chk("restart_from_run", {pc_reset, done, busy}, 3'b101);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hC1);
    byte_valid = 1'b0;
    chk("badsum_state", {pc_reset, done, error, busy}, 4'b1010);
    check_nominal_writes("badsum");

    // Zero length
    writes.delete();
    pulse_start();
    chk("error_cleared", {31'd0, error}, 32'd0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    byte_valid = 1'b0;
    chk("zero_run", {pc_reset, done, error}, 3'b010);
    chk("zero_writes", 32'(writes.size()), 32'd0);

    // Oversize length (257 > 256)
    writes.delete();
    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    byte_in = 8'h55;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    chk("oversize_state", {pc_reset, done, error, busy, byte_ready}, 5'b10100);
    chk("oversize_writes", 32'(writes.size()), 32'd0);

    // Length exactly MAX_WORDS is accepted: stalls in DATA_HI
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    byte_valid = 1'b0;
    @(negedge clk);
    chk("maxlen_accepted", {error, busy, byte_ready}, 3'b011);

    // Reset mid-load (state is abandoned)
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_maxlen");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Backpressure and gaps
    writes.delete();
    pulse_start();
    send_nominal(1'b1);
    chk("gaps_run", {pc_reset, done, error}, 3'b010);
    check_nominal_writes("gaps");

    // Reset after 00 02 12
    pulse_start();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
    byte_valid = 1'b0;
    chk("partial_hi", {16'd0, instruction_in[15:8], 8'h00}, 32'h0000_1200);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    writes.delete();
    pulse_start();
    send_nominal(1'b0);
    chk("after_rst_run", {pc_reset, done, error}, 3'b010);
    check_nominal_writes("after_rst");

    // Reset during WRITE drops the strobe asynchronously
    pulse_start();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    byte_valid = 1'b0;
    chk("in_write", {load_instruction, load_address, instruction_in}, {1'b1, 16'h0000, 16'h1234});
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_write");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
